// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem request, valid/ready delivery to decode,
// redirect squashing of in-flight work, and a terminal halt once EBREAK is handed downstream.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  // One-hot so each status output is a flop bit of the state register.
  typedef enum logic [4:0] {
    S_BOOT = 5'b00001,
    S_REQ  = 5'b00010,
    S_WAIT = 5'b00100,
    S_HOLD = 5'b01000,
    S_HALT = 5'b10000
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic [31:0] target;

  assign target         = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req_valid = state[1];
  assign imem_req_addr  = pc & {32{state[1]}};
  assign out_valid      = state[3];
  assign halted         = state[4];

  // drop marks an accepted request whose response must be thrown away after a redirect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_BOOT;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      out_inst <= '0;
      out_pc   <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          if (redirect_valid) pc <= target;
          state <= S_REQ;
        end
        S_REQ: begin
          if (redirect_valid) begin
            pc <= target;
            if (imem_req_ready) begin
              drop  <= 1'b1;
              state <= S_WAIT;
            end
          end else if (imem_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc <= target;
            if (imem_resp_valid) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              out_inst <= imem_resp_data;
              out_pc   <= pc;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // A redirect squashes the held instruction even if downstream is ready.
          if (redirect_valid) begin
            pc    <= target;
            state <= S_REQ;
          end else if (out_ready) begin
            if (out_inst == EBREAK_INST) begin
              state <= S_HALT;
            end else begin
              pc    <= pc + 32'd4;
              state <= S_REQ;
            end
          end
        end
        S_HALT: state <= S_HALT;
        default: begin
          state <= S_BOOT;
          drop  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: a transaction-level model of the fetch unit and a
// one-slot memory with variable latency, checked every cycle.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  ifu_fetch #(.RESET_PC(RESET_PC), .EBREAK_INST(EBREAK)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // What the fetch unit is doing with its single instruction slot.
  typedef enum int {PH_ISSUE, PH_INMEM, PH_HELD} phase_t;

  phase_t      mPhase;
  logic        mBoot;
  logic        mHalt;
  logic        mDoomed;
  logic [31:0] mPc;
  logic [31:0] mHeldPc;
  logic [31:0] mInst;

  logic        memBusy;
  logic [31:0] memAddr;
  int          memDelay;
  int          memMin = 1;
  int          memMax = 1;
  int          spurPct = 0;
  logic [31:0] ebreakAddr = 32'h1;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    logic [31:0] d;
    if (a == ebreakAddr) return EBREAK;
    d = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    if (d == EBREAK) d = d ^ 32'h100;
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mBoot   = 1'b1;
    mHalt   = 1'b0;
    mDoomed = 1'b0;
    mPhase  = PH_ISSUE;
    mPc     = RESET_PC;
    mHeldPc = '0;
    mInst   = '0;
    memBusy = 1'b0;
    memDelay = 0;
  endtask

  // Called at a falling edge: check outputs, drive this cycle's inputs, advance the model.
  task automatic applyStimulus(input logic rdy, input logic ordy, input logic rv, input logic [31:0] rpc);
    logic        expReq;
    logic        expOut;
    logic        respNow;
    logic [31:0] tgt;
    expReq = !mHalt && !mBoot && (mPhase == PH_ISSUE);
    expOut = !mHalt && !mBoot && (mPhase == PH_HELD);
    checkOutput("req_valid", 32'(imem_req_valid), 32'(expReq));
    checkOutput("req_addr", imem_req_addr, expReq ? mPc : 32'h0);
    checkOutput("out_valid", 32'(out_valid), 32'(expOut));
    if (expOut || mBoot) begin
      checkOutput("out_inst", out_inst, mBoot ? 32'h0 : mInst);
      checkOutput("out_pc", out_pc, mBoot ? 32'h0 : mHeldPc);
    end
    checkOutput("halted", 32'(halted), 32'(mHalt));

    imem_req_ready  = rdy;
    out_ready       = ordy;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (memBusy) begin
      if (memDelay <= 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memFn(memAddr);
        memBusy         = 1'b0;
      end else begin
        memDelay--;
      end
    end else if (mPhase != PH_INMEM && $urandom_range(0, 99) < spurPct) begin
      imem_resp_valid = 1'b1;
    end
    if (imem_req_valid && rdy) begin
      memBusy  = 1'b1;
      memAddr  = imem_req_addr;
      memDelay = $urandom_range(memMin, memMax);
    end
    respNow = imem_resp_valid;
    tgt     = rpc & 32'hFFFF_FFFC;

    if (!mHalt) begin
      if (mBoot) begin
        mBoot = 1'b0;
        if (rv) mPc = tgt;
      end else begin
        case (mPhase)
          PH_ISSUE: begin
            if (rdy) begin
              mPhase  = PH_INMEM;
              mDoomed = rv;
            end
            if (rv) mPc = tgt;
          end
          PH_INMEM: begin
            if (respNow) begin
              if (rv || mDoomed) begin
                mPhase  = PH_ISSUE;
                mDoomed = 1'b0;
                if (rv) mPc = tgt;
              end else begin
                mPhase  = PH_HELD;
                mHeldPc = mPc;
                mInst   = memFn(mPc);
              end
            end else if (rv) begin
              mPc     = tgt;
              mDoomed = 1'b1;
            end
          end
          PH_HELD: begin
            if (rv) begin
              mPc    = tgt;
              mPhase = PH_ISSUE;
            end else if (ordy) begin
              if (mInst == EBREAK) begin
                mHalt = 1'b1;
              end else begin
                mPc    = mPc + 32'd4;
                mPhase = PH_ISSUE;
              end
            end
          end
          default: mPhase = PH_ISSUE;
        endcase
      end
    end
    @(negedge clock);
  endtask

  // Asserts reset a little after a falling edge and expects every output to clear at once.
  task automatic applyReset();
    #2;
    reset           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    #1;
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
    checkOutput("rst_req_addr", imem_req_addr, 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_inst", out_inst, 32'h0);
    checkOutput("rst_out_pc", out_pc, 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    modelReset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] pickTarget();
    case ($urandom_range(0, 3))
      0: return RESET_PC + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      1: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      2: return $urandom;
      default: return RESET_PC;
    endcase
  endfunction

  task automatic runCycles(input int n, input int rdyPct, input int ordyPct, input int redirPct);
    for (int i = 0; i < n; i++) begin
      applyStimulus($urandom_range(0, 99) < rdyPct, $urandom_range(0, 99) < ordyPct,
                    $urandom_range(0, 99) < redirPct, pickTarget());
    end
  endtask

  // Fires one redirect when the model reaches the requested situation; 0 = waiting on a
  // response that is not arriving this cycle, 1 = instruction held for downstream.
  task automatic redirectAt(input int where, input logic [31:0] tgt, input int cycles);
    logic done;
    logic hit;
    done = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (where == 0) hit = !done && !mBoot && mPhase == PH_INMEM && memBusy && memDelay > 1;
      else            hit = !done && !mBoot && mPhase == PH_HELD;
      applyStimulus(1'b1, 1'b1, hit, tgt);
      if (hit) done = 1'b1;
    end
    checkOutput("redirect_reached", 32'(done), 32'h1);
  endtask

  initial begin
    reset           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    modelReset();
    @(negedge clock);

    // Back-to-back fetch with a single-cycle memory, then a downstream stall.
    applyReset();
    runCycles(12, 100, 100, 0);
    runCycles(8, 100, 0, 0);
    runCycles(6, 100, 100, 0);

    // EBREAK at the third word halts fetch; later redirects are ignored.
    ebreakAddr = RESET_PC + 32'd8;
    applyReset();
    runCycles(15, 100, 100, 0);
    checkOutput("halt_reached", 32'(mHalt), 32'h1);
    runCycles(20, 100, 100, 100);
    ebreakAddr = 32'h1;

    // Redirect while a response is still outstanding, then while holding.
    memMin = 2;
    memMax = 2;
    applyReset();
    redirectAt(0, 32'h8000_0103, 8);
    runCycles(10, 100, 100, 0);
    memMin = 1;
    memMax = 1;
    applyReset();
    redirectAt(1, 32'h8000_0200, 8);
    runCycles(8, 100, 100, 0);

    // PC wrap at the top of the address space.
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    runCycles(10, 100, 100, 0);

    // Reset landing while a response is outstanding.
    memMin = 3;
    memMax = 3;
    applyReset();
    for (int i = 0; i < 10 && !(mPhase == PH_INMEM && !mBoot); i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wait_reached", 32'(mPhase == PH_INMEM), 32'h1);
    applyReset();
    memMin = 1;
    memMax = 1;
    runCycles(10, 100, 100, 0);

    // Randomized episodes with spurious responses, variable latency and random redirects.
    spurPct = 10;
    for (int ep = 0; ep < 6; ep++) begin
      ebreakAddr = RESET_PC + 32'($urandom_range(4, 60) * 4);
      memMin = 1;
      memMax = $urandom_range(1, 4);
      applyReset();
      runCycles(300, $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 15));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the simulation/EBREAK monitor and the decode stage.
- Holds the PC, issues one instruction-memory request at a time, and presents the fetched word with its PC on a valid/ready output.
- Accepts PC redirects from execute.
- On delivering EBREAK (0x00100073), stops fetching and raises halted so the monitor ends simulation.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset
EBREAK_INST, 32'h0010_0073, encoding that halts fetch

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  32  word-aligned fetch address
imem_resp_valid  in  1  response data valid (one per accepted request)
imem_resp_data  in  32  fetched instruction word
out_valid  out  1  instruction valid to downstream
out_ready  in  1  downstream accepts instruction
out_inst  out  32  instruction word
out_pc  out  32  PC of out_inst
redirect_valid  in  1  PC redirect strobe
redirect_pc  in  32  redirect target; bits [1:0] forced to 0
halted  out  1  EBREAK delivered, fetch stopped

Behaviour:
- Reset asserted (async): state=BOOT, pc=RESET_PC, drop=0, out_inst=0, out_pc=0. All outputs are 0 during reset and in BOOT.
- States: BOOT, REQ, WAIT, HOLD, HALT. One outstanding request maximum.
- BOOT: unconditionally goes to REQ next cycle. First imem_req_valid appears 1 cycle after reset release.
- REQ: imem_req_valid=1, imem_req_addr=pc.
  - req_ready=1 -> WAIT.
  - The addr is held stable while valid and not ready, except on redirect.
- WAIT: waits for imem_resp_valid.
  - drop=0: latch out_inst=resp_data, out_pc=pc -> HOLD.
  - drop=1: discard the response, clear drop -> REQ.
- HOLD: out_valid=1; out_inst/out_pc stable until handshake.
  - Handshake (out_valid & out_ready): if out_inst==EBREAK_INST -> HALT; else pc<=pc+4 -> REQ.
- HALT: halted=1, no requests, out_valid=0. Only reset exits.
- Redirect priority is above all normal transitions. target = {redirect_pc[31:2],2'b00}.
  - REQ, req_ready=0: pc<=target, stay REQ.
  - REQ, req_ready=1 same cycle: old-address request is accepted; pc<=target, drop<=1 -> WAIT.
  - WAIT, no resp: pc<=target, drop<=1.
  - WAIT, resp same cycle: discard resp, pc<=target -> REQ.
  - HOLD: out_valid drops next cycle, pc<=target -> REQ, even if out_ready=1 that cycle (the instruction is squashed, not delivered).
  - BOOT: pc<=target, go to REQ.
  - HALT: ignored.
- pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- imem_resp_valid outside WAIT is ignored.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD).
  - With req_ready=1, resp in the cycle after acceptance, and out_ready=1: out_valid rises 2 cycles after the request cycle.
- Reset asserted mid-operation returns to BOOT immediately. Any in-flight response is ignored; the memory model must also be reset.

Test Plan:
- Reset release, ready memory returning 0x00000013 at every address, out_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008; out_pc matches each; out_valid rises 3 cycles after reset release.
- out_ready held 0 for 5 cycles with out_inst=0x00500093 -> out_valid, out_inst and out_pc stay stable; no new request issued; after ready, next addr = pc+4.
- Memory returns 0x00100073 at 0x80000008 -> halted=1 the cycle after handshake; no further imem_req_valid for 20 cycles; redirect ignored.
- Redirect to 0x80000103 in the WAIT cycle before the response -> stale response discarded (out_valid stays 0); next request addr 0x80000100.
- Redirect to 0x80000200 in HOLD with out_ready=1 -> instruction not delivered; next request addr 0x80000200.
- Redirect to 0xFFFFFFFC, memory returns 0x00000013 -> out_pc 0xFFFFFFFC, then next request 0x00000000. Separately, reset pulsed low while in WAIT -> all outputs 0 immediately; fetch restarts at 0x80000000.
